// File: rtl/uart_cmd_pkg.sv
// Shared command/reply codes, frame geometry and FSM encoding for the UART command responder.
package uart_cmd_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] ACK       = 8'h06;
  localparam logic [7:0] NAK       = 8'h15;

  localparam int FRAME_ADDR_BYTES = 4;
  localparam int FRAME_DATA_BYTES = 4;

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_DATA, S_BUS, S_ACK, S_NAK, S_RDATA
  } state_t;
endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: clears on clr, counts while en, flags expiry at all-ones.
module uart_cmd_timer #(
  parameter int W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [W-1:0] count;

  assign expire = en && (&count);

  always_ff @(posedge clk) begin
    if (rst || clr || expire) count <= '0;
    else if (en)              count <= count + 1'b1;
  end
endmodule

// File: rtl/uart_cmd_responder.sv
// Serial-to-memory bridge: decodes write/read frames from the UART byte interface and replies.
// Optional inter-byte timeout is enabled with `define UART_CMD_TIMEOUT_EN.
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_ready,
  output logic                data_read_en,
  input  logic                tx_ready,
  output logic [7:0]          tx_data,
  output logic                data_write_en,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                busy,
  output logic                err
);
  localparam logic [1:0] LAST_A = 2'(FRAME_ADDR_BYTES - 1);
  localparam logic [1:0] LAST_D = 2'(FRAME_DATA_BYTES - 1);

  state_t state, state_nx;
  logic                          op_wr;
  logic [1:0]                    cnt;
  logic [8*FRAME_ADDR_BYTES-1:0] addr_r;
  logic [DATA_W-1:0]             wdata_r, rdata_r;
  logic [7:0]                    rx_byte, tx_byte;
  logic                          rd_d1, tx_armed;
  logic                          take, launch, rx_state, tx_state, bad_cmd, tmo;

  // data_read_en doubles as "captured byte is valid this cycle"
  assign bad_cmd = (rx_byte != CMD_WRITE) && (rx_byte != CMD_READ);

`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timer #(.W(TIMEOUT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (data_read_en),
    .en     (state == S_ADDR || state == S_DATA),
    .expire (tmo)
  );
`else
  logic [TIMEOUT_W-1:0] unused_timeout;
  assign unused_timeout = '0;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_CMD;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_CMD:   if (data_read_en) state_nx = bad_cmd ? S_NAK : S_ADDR;
      S_ADDR:  if (data_read_en && cnt == LAST_A) state_nx = op_wr ? S_DATA : S_BUS;
      S_DATA:  if (data_read_en && cnt == LAST_D) state_nx = S_BUS;
      S_BUS:   if (m_ready) state_nx = op_wr ? S_ACK : S_RDATA;
      S_ACK,
      S_NAK:   if (launch) state_nx = S_CMD;
      S_RDATA: if (launch && cnt == LAST_D) state_nx = S_CMD;
      default: state_nx = S_CMD;
    endcase
    if (tmo) state_nx = S_CMD;
  end

  always_comb begin
    rx_state = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
    tx_state = (state == S_ACK) || (state == S_NAK) || (state == S_RDATA);
    // The core drops rx_ready late, so skip the two samples after a capture
    take     = rx_state && rx_ready && !data_read_en && !rd_d1 && !tmo;
    launch   = tx_state && tx_armed && tx_ready;
    case (state)
      S_ACK:   tx_byte = ACK;
      S_NAK:   tx_byte = NAK;
      default: tx_byte = rdata_r[{cnt, 3'b000} +: 8];
    endcase
    m_valid = (state == S_BUS);
    busy    = (state != S_CMD);
    m_wstrb = {(DATA_W/8){m_valid & op_wr}};
  end

  assign m_addr  = addr_r[ADDR_W-1:0];
  assign m_wdata = wdata_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_read_en  <= 1'b0;
      rd_d1         <= 1'b0;
      rx_byte       <= '0;
      data_write_en <= 1'b0;
      tx_data       <= '0;
      tx_armed      <= 1'b1;
      err           <= 1'b0;
      op_wr         <= 1'b0;
      cnt           <= '0;
      addr_r        <= '0;
      wdata_r       <= '0;
      rdata_r       <= '0;
    end else begin
      data_read_en  <= take;
      rd_d1         <= data_read_en;
      data_write_en <= launch;
      err           <= (state == S_CMD && data_read_en && bad_cmd) || tmo;
      if (take)   rx_byte <= rx_data;
      if (launch) tx_data <= tx_byte;
      // Re-arm only after tx_ready has been seen low following a launch
      if (launch)         tx_armed <= 1'b0;
      else if (!tx_ready) tx_armed <= 1'b1;
      if (state == S_CMD && data_read_en) op_wr <= (rx_byte == CMD_WRITE);
      if (state_nx != state)
        cnt <= '0;
      else if ((data_read_en && (state == S_ADDR || state == S_DATA)) ||
               (launch && state == S_RDATA))
        cnt <= cnt + 1'b1;
      if (state == S_ADDR && data_read_en) addr_r[{cnt, 3'b000} +: 8]  <= rx_byte;
      if (state == S_DATA && data_read_en) wdata_r[{cnt, 3'b000} +: 8] <= rx_byte;
      if (state == S_BUS && m_ready && !op_wr) rdata_r <= m_rdata;
    end
  end
endmodule
